// File: rtl/fpmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpmul_arbiter                                                              |
// | Round-robin sharing of one pipelined FP multiplier among N_REQ requesters. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpmul_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  input  logic [31:0]         mul_z,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_z,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [c_PW-1:0] r_ptr;
  logic [31:0]     r_mul_a;
  logic [31:0]     r_mul_b;
  logic [15:0]     r_op_count;
  logic [LAT:0]    r_tag_v;
  logic [c_PW-1:0] r_tag_id [0:LAT];

  logic            w_found;
  logic            w_grant;
  logic [c_PW-1:0] w_sel;

  function automatic logic [c_PW-1:0] wrap_idx(input logic [c_PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[c_PW-1:0];
  endfunction

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && req_valid[wrap_idx(r_ptr, j)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_ptr, j);
      end
    end
  end

  assign w_grant = w_found & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_op_count <= '0;
      r_tag_v    <= '0;
    end else begin
      // Operands hold when idle so the multiplier inputs stay quiet.
      if (w_grant) begin
        r_ptr      <= wrap_idx(w_sel, 1);
        r_mul_a    <= req_a[{w_sel, 5'd0} +: 32];
        r_mul_b    <= req_b[{w_sel, 5'd0} +: 32];
        r_op_count <= r_op_count + 16'd1;
      end
      r_tag_v <= {r_tag_v[LAT-1:0], w_grant};
    end
  end

  // Tag ids only matter alongside their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_sel;
    for (int k = 1; k <= LAT; k++) begin
      r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_tag_v[LAT]) rsp_valid[r_tag_id[LAT]] = 1'b1;
  end

  assign rsp_z    = mul_z;
  assign busy     = |r_tag_v;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Round-robin arbiter and scheduler that shares one pipelined single-precision multiplier (the `wrapped` FP multiplier, ports FP_A/FP_B/clk/FP_Z) among N_REQ requesters. It sits between the requester blocks and the multiplier, and grants at most one operand pair per cycle. It registers the granted operands onto the multiplier inputs and tracks each in-flight operation with a tag pipeline matched to the multiplier latency. Each result goes back to its originating requester with a one-hot valid.

## Interface
- N_REQ, 4: number of requesters (2..8).
- LAT, 4: multiplier latency, in clock edges, from an FP_A/FP_B change to the corresponding FP_Z change (≥1).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  N_REQ  request pending per requester.
- req_a  in  32*N_REQ  operand A, requester i at bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing.
- req_ready  out  N_REQ  one-hot grant (combinational); the transfer happens when req_valid[i] and req_ready[i] are both high.
- mul_a  out  32  registered operand to FP_A.
- mul_b  out  32  registered operand to FP_B.
- mul_z  in  32  product from FP_Z.
- rsp_valid  out  N_REQ  one-hot result strobe, one cycle.
- rsp_z  out  32  result word, equal to mul_z.
- busy  out  1  high while any tag is in flight.
- op_count  out  16  count of issued operations; wraps at 0xFFFF→0.

## Operation
- Round-robin pointer ptr, width clog2(N_REQ):
  - Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, … modulo N_REQ.
  - On a grant to i, ptr ← (i+1) mod N_REQ.
  - With no requests, ptr holds.
- At most one grant per cycle. req_ready is all-zero when req_valid is all-zero.
- On a grant to i:
  - mul_a ← req_a[i], mul_b ← req_b[i].
  - Tag stage 0 ← {1, i}.
  - op_count increments.
- With no grant:
  - mul_a and mul_b hold their last values, to avoid multiplier toggling.
  - Tag stage 0 ← {0, x}.
- Tag pipeline has stages 0..LAT, shifted every cycle unconditionally. The multiplier cannot stall and there is no backpressure on responses.
- rsp_valid = one-hot(id) of stage LAT when its valid bit is set, else 0. rsp_z = mul_z passthrough, meaningful only when rsp_valid ≠ 0.
- busy = OR of the valid bits of tag stages 0..LAT.
- Requesters must accept rsp_valid in the cycle it is asserted. The arbiter does not buffer results.
- Operands are not inspected. NaN, Inf and denormal handling belongs to the multiplier.

## Timing
- Handshake in cycle n:
  - mul_a/mul_b carry the operands in cycle n+1.
  - mul_z carries the product in cycle n+1+LAT.
  - rsp_valid[i] is high in cycle n+1+LAT only.
- Throughput is one operation per cycle. Back-to-back grants give back-to-back responses, in issue order.
- A request held continuously with other requesters idle is granted every cycle.
- Fairness: with all N_REQ requesters valid continuously, each is granted exactly once every N_REQ cycles.
- A requester that drops req_valid before being granted causes no transfer, and the pointer is unchanged for it.
- Reset (rst high at a rising edge) sets:
  - ptr=0, mul_a=0, mul_b=0.
  - All tag valid bits 0, op_count=0.
  - Outputs after reset: rsp_valid=0, busy=0, req_ready combinational from req_valid with ptr=0.
- rst asserted mid-operation discards every in-flight tag. No rsp_valid is asserted for operations issued before reset, even though mul_z continues to drain.
- While rst is high, req_ready is forced to 0 and nothing is issued.

## Test plan
- Single op: after reset, requester 1 presents 0x40000000 × 0x40400000 (2.0×3.0) for one cycle at cycle n. Required: rsp_valid=4'b0010 and rsp_z=0x40C00000 (6.0) in cycle n+1+LAT, nothing at any other cycle, and op_count=1.
- Full contention: all four requesters valid for 8 cycles, each with a distinct operand pair (requester i: A=0x3FC00000 (1.5), B=i+1 as float). Required:
  - Grant sequence 0,1,2,3,0,1,2,3.
  - Responses in the same order, LAT+1 cycles later.
  - First product 0x3FC00000 (1.5×1.0).
- Pointer fairness: requesters 0 and 2 valid continuously, with ptr=1 after a prior grant to 0. Required: grants alternate 2,0,2,0, and requester 0 is never granted twice in a row.
- Idle hold: one op issued and then no requests for 10 cycles. Required: mul_a/mul_b are unchanged during the idle cycles, and busy falls exactly LAT+1 cycles after the last issue.
- Reset mid-flight: 3 ops issued on consecutive cycles, then rst pulsed one cycle after the last issue. Required: no rsp_valid for those ops, busy=0, op_count=0, ptr=0, and the first post-reset request is serviced normally.
- op_count wrap: 65537 single-requester ops issued. Required: op_count reads 1.
